// File: rtl/serial_bus_arbiter_pkg.sv
// Shared encodings for the serial bus arbiter: owner codes, FSM states and default sizing.
package serial_bus_arbiter_pkg;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M1   = 2'b01;
  localparam logic [1:0] OWNER_M2   = 2'b10;

  localparam int DEFAULT_HOLD_TIMEOUT = 256;
  localparam int DEFAULT_CNT_WIDTH    = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M1 = 2'd1,
    ST_OWN_M2 = 2'd2,
    ST_RESUME = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_hold_timer.sv
// Grant-hold watchdog: counts owned cycles and flags the last permitted one.
module arb_hold_timer #(
  parameter int HOLD_TIMEOUT = 256,
  parameter int CNT_WIDTH    = 9
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // Expire during the HOLD_TIMEOUT-th owned cycle so the grant is visible exactly that long.
  assign expire = (HOLD_TIMEOUT != 0) && enable &&
                  (count == CNT_WIDTH'(HOLD_TIMEOUT - 1));

endmodule

// File: rtl/serial_bus_arbiter.sv
// Two-master registered bus arbiter with fixed/round-robin priority, split parking and hold watchdog.
module serial_bus_arbiter
  import serial_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN        = 1'b1,
  parameter int HOLD_TIMEOUT = DEFAULT_HOLD_TIMEOUT,
  parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_breq,
  input  logic       m2_breq,
  output logic       m1_bgrant,
  output logic       m2_bgrant,
  output logic       m1_split,
  output logic       m2_split,
  input  logic       s_split,
  input  logic       s_split_ready,
  output logic       split_grant,
  output logic [1:0] bus_owner,
  output logic       timeout_err,
  output arb_state_t dbg_state
);

  // Requests are levels held by the masters; a grant is a level that stays high
  // while the owner keeps breq high, and the bus always idles one cycle between owners.

  arb_state_t state;
  logic [1:0] last_owner;
  logic       split_pend, elig1, elig2, pick_m1, own_breq, owned, expire;
  logic       take_split, release_bus;

  assign split_pend  = m1_split | m2_split;
  assign elig1       = m1_breq & ~m1_split;
  assign elig2       = m2_breq & ~m2_split;
  assign pick_m1     = elig1 & (~elig2 | ~RR_EN | (last_owner == OWNER_M2));
  assign own_breq    = (bus_owner == OWNER_M1) ? m1_breq : m2_breq;
  assign owned       = (state == ST_OWN_M1) || (state == ST_OWN_M2);
  assign take_split  = s_split & ~split_pend;
  assign release_bus = take_split | ~own_breq | expire;
  assign dbg_state   = state;

  arb_hold_timer #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_hold_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clear (~owned),
    .enable(owned),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      last_owner  <= OWNER_M2;
      m1_bgrant   <= 1'b0;
      m2_bgrant   <= 1'b0;
      m1_split    <= 1'b0;
      m2_split    <= 1'b0;
      split_grant <= 1'b0;
      bus_owner   <= OWNER_NONE;
      timeout_err <= 1'b0;
    end else begin
      split_grant <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (split_pend && s_split_ready) begin
            state       <= ST_RESUME;
            split_grant <= 1'b1;
            if (m1_split) begin
              m1_split  <= 1'b0;
              m1_bgrant <= 1'b1;
              bus_owner <= OWNER_M1;
            end else begin
              m2_split  <= 1'b0;
              m2_bgrant <= 1'b1;
              bus_owner <= OWNER_M2;
            end
          end else if (pick_m1) begin
            state     <= ST_OWN_M1;
            m1_bgrant <= 1'b1;
            bus_owner <= OWNER_M1;
          end else if (elig2) begin
            state     <= ST_OWN_M2;
            m2_bgrant <= 1'b1;
            bus_owner <= OWNER_M2;
          end
        end
        ST_OWN_M1, ST_OWN_M2: begin
          if (release_bus) begin
            state     <= ST_IDLE;
            m1_bgrant <= 1'b0;
            m2_bgrant <= 1'b0;
            bus_owner <= OWNER_NONE;
            if (take_split) begin
              if (bus_owner == OWNER_M1) m1_split <= 1'b1;
              else                       m2_split <= 1'b1;
            end else begin
              // With breq still high the release can only have come from the watchdog.
              last_owner  <= bus_owner;
              timeout_err <= own_breq;
            end
          end
        end
        ST_RESUME: begin
          if (own_breq) begin
            state <= (bus_owner == OWNER_M1) ? ST_OWN_M1 : ST_OWN_M2;
          end else begin
            state      <= ST_IDLE;
            last_owner <= bus_owner;
            m1_bgrant  <= 1'b0;
            m2_bgrant  <= 1'b0;
            bus_owner  <= OWNER_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench: a round-robin/watchdog instance and a fixed-priority/no-watchdog instance share stimulus.
module tb_serial_bus_arbiter;
  import serial_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m1_breq = 1'b0, m2_breq = 1'b0, s_split = 1'b0, s_split_ready = 1'b0;

  logic       rr_m1_bgrant, rr_m2_bgrant, rr_m1_split, rr_m2_split, rr_split_grant, rr_timeout_err;
  logic [1:0] rr_bus_owner;
  arb_state_t rr_state;
  logic       fp_m1_bgrant, fp_m2_bgrant, fp_m1_split, fp_m2_split, fp_split_grant, fp_timeout_err;
  logic [1:0] fp_bus_owner;
  arb_state_t fp_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter #(.RR_EN(1'b1), .HOLD_TIMEOUT(8), .CNT_WIDTH(9)) dut_rr (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(rr_m1_bgrant), .m2_bgrant(rr_m2_bgrant),
    .m1_split(rr_m1_split), .m2_split(rr_m2_split),
    .s_split(s_split), .s_split_ready(s_split_ready),
    .split_grant(rr_split_grant), .bus_owner(rr_bus_owner),
    .timeout_err(rr_timeout_err), .dbg_state(rr_state)
  );

  serial_bus_arbiter #(.RR_EN(1'b0), .HOLD_TIMEOUT(0), .CNT_WIDTH(9)) dut_fp (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(fp_m1_bgrant), .m2_bgrant(fp_m2_bgrant),
    .m1_split(fp_m1_split), .m2_split(fp_m2_split),
    .s_split(s_split), .s_split_ready(s_split_ready),
    .split_grant(fp_split_grant), .bus_owner(fp_bus_owner),
    .timeout_err(fp_timeout_err), .dbg_state(fp_state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m1_breq = 1'b0; m2_breq = 1'b0; s_split = 1'b0; s_split_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // {m1_bgrant, m2_bgrant, m1_split, m2_split, split_grant, timeout_err, bus_owner}
  function automatic logic [7:0] rr_vec();
    return {rr_m1_bgrant, rr_m2_bgrant, rr_m1_split, rr_m2_split,
            rr_split_grant, rr_timeout_err, rr_bus_owner};
  endfunction

  // Expected bus_owner after each of 11 edges of the contention test.
  logic [1:0] exp_rr[11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_fp[11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

  initial begin
    // Reset state
    rstn = 1'b0;
    #2;
    check("reset_outputs_rr", rr_vec(), 8'h00);
    check("reset_state_rr", 8'(rr_state), 8'(ST_IDLE));
    check("reset_owner_fp", {6'd0, fp_bus_owner}, 8'h00);
    do_reset();

    // 1. Single request with 1-cycle latency, then release
    tick(); tick();
    m1_breq = 1'b1;
    check("single_before_edge", {7'd0, fp_m1_bgrant}, 8'h00);
    tick();
    check("single_grant", {fp_m1_bgrant, fp_m2_bgrant, 4'd0, fp_bus_owner}, {2'b10, 4'd0, 2'b01});
    for (int i = 0; i < 14; i++) tick();
    check("single_held", {7'd0, fp_m1_bgrant}, 8'h01);
    m1_breq = 1'b0;
    tick();
    check("single_release", {fp_m1_bgrant, 5'd0, fp_bus_owner}, 8'h00);

    // 2. Contention: RR alternates with 1-cycle gaps, fixed priority keeps m1
    do_reset();
    m1_breq = 1'b1; m2_breq = 1'b1;
    for (int e = 0; e < 11; e++) begin
      tick();
      check($sformatf("rr_owner_e%0d", e + 1), {6'd0, rr_bus_owner}, {6'd0, exp_rr[e]});
      check($sformatf("fp_owner_e%0d", e + 1), {6'd0, fp_bus_owner}, {6'd0, exp_fp[e]});
      m1_breq = (e == 3) ? 1'b0 : 1'b1;
      m2_breq = (e == 8) ? 1'b0 : 1'b1;
    end
    check("rr_grant_e11", {6'd0, rr_m1_bgrant, rr_m2_bgrant}, 8'b10);

    // 3. Split while m2 waits; ready while m2 owns waits for release
    do_reset();
    m1_breq = 1'b1;
    tick();
    check("split_m1_own", rr_vec(), 8'b1000_0001);
    m2_breq = 1'b1; s_split = 1'b1;
    tick();
    s_split = 1'b0;
    check("split_parked", rr_vec(), 8'b0010_0000);
    tick();
    check("split_m2_own", rr_vec(), 8'b0110_0010);
    s_split_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("split_ready_waits", rr_vec(), 8'b0110_0010);
    m2_breq = 1'b0;
    tick();
    check("split_m2_release", rr_vec(), 8'b0010_0000);
    tick();
    check("split_resume", rr_vec(), 8'b1000_1001);
    check("split_resume_state", 8'(rr_state), 8'(ST_RESUME));
    s_split_ready = 1'b0;
    tick();
    check("split_after_resume", rr_vec(), 8'b1000_0001);
    check("split_own_state", 8'(rr_state), 8'(ST_OWN_M1));

    // 4. Split masking and second split ignored
    do_reset();
    m1_breq = 1'b1;
    tick();
    s_split = 1'b1;
    tick();
    s_split = 1'b0;
    tick(); tick(); tick();
    check("mask_no_grant", rr_vec(), 8'b0010_0000);
    m2_breq = 1'b1;
    tick();
    check("mask_m2_own", rr_vec(), 8'b0110_0010);
    s_split = 1'b1;
    tick();
    s_split = 1'b0;
    check("mask_second_split", rr_vec(), 8'b0110_0010);
    m2_breq = 1'b0;
    tick();
    s_split_ready = 1'b1;
    tick();
    check("mask_resume", rr_vec(), 8'b1000_1001);
    s_split_ready = 1'b0;

    // 5. Watchdog revokes after 8 owned cycles; disabled instance keeps grant
    do_reset();
    m2_breq = 1'b1;
    tick();
    check("wd_m2_own", rr_vec(), 8'b0100_0010);
    m1_breq = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("wd_cycle8", rr_vec(), 8'b0100_0010);
    tick();
    check("wd_revoke", rr_vec(), 8'b0000_0100);
    check("wd_disabled_fp", {6'd0, fp_m2_bgrant, fp_timeout_err}, 8'b10);
    tick();
    check("wd_m1_next", rr_vec(), 8'b1000_0001);

    // 6. Asynchronous reset mid-ownership
    do_reset();
    m1_breq = 1'b1;
    tick();
    check("areset_own", {7'd0, rr_m1_bgrant}, 8'h01);
    #2;
    rstn = 1'b0;
    #1;
    check("areset_drop", rr_vec(), 8'h00);
    check("areset_drop_fp", {6'd0, fp_m1_bgrant, 1'b0}, 8'h00);
    m1_breq = 1'b0; m2_breq = 1'b1;
    #2;
    rstn = 1'b1;
    check("areset_wait", {7'd0, rr_m2_bgrant}, 8'h00);
    tick();
    check("areset_m2_grant", rr_vec(), 8'b0100_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
